interval_capture: RTL and testbench

- Measurement counterpart of the timer block. The timer turns a programmed delay into an interrupt; this block turns an external event interval back into a programmed-style count.
- It measures either a pulse width (rising to falling edge) or a period (rising to rising edge) of an asynchronous input.
- The count is in prescaled ticks of clk. The result is latched and capture_it is raised.
- Sits beside the timer on the peripheral bus side; software arms it and reads the count.

---
 rtl/interval_capture_pkg.sv | 17 +
 rtl/sync_edge.sv | 31 +++
 rtl/interval_capture.sv | 128 ++++++++++++
 tb/tb_interval_capture.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/interval_capture_pkg.sv
// Shared types and constants for the interval capture block and its
// synchronizer front end.
package interval_capture_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic MODE_PULSE  = 1'b0;
  localparam logic MODE_PERIOD = 1'b1;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer followed by an edge detector against one more
// registered copy; rise/fall are single-cycle strobes with equal latency.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_async,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_async};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/interval_capture.sv
// Measures pulse width (rise->fall) or period (rise->rise) of an async input
// in prescaled clk ticks; latches the count and raises a level interrupt.
module interval_capture
  import interval_capture_pkg::*;
#(
  parameter int A_WIDTH   = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 arm,
  input  logic                 mode,
  input  logic [A_WIDTH-1:0]   div_a,
  input  logic                 event_in,
  output logic [CNT_WIDTH-1:0] capture,
  output logic                 overflow,
  output logic                 busy,
  output logic                 capture_it
);

  localparam logic [CNT_WIDTH-1:0] TICK_MAX = '1;

  state_e               state_q;
  logic [A_WIDTH-1:0]   pre_q, pre_d, period;
  logic [CNT_WIDTH-1:0] tick_q, tick_d, capture_q;
  logic                 sat_q, sat_d;
  logic                 mode_q, overflow_q, busy_q, capture_it_q;
  logic                 ev_rise, ev_fall, ev_level_unused;
  logic                 wrap, stop;

  sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .d_async (event_in),
    .level   (ev_level_unused),
    .rise    (ev_rise),
    .fall    (ev_fall)
  );

  // Next tick/prescaler values include the current cycle, so a stop strobe
  // N cycles after the start strobe latches exactly floor(N/P).
  always_comb begin
    period = (div_a == '0) ? A_WIDTH'(1) : div_a;
    wrap   = (pre_q >= period - A_WIDTH'(1));
    pre_d  = wrap ? '0 : pre_q + A_WIDTH'(1);
    tick_d = tick_q;
    sat_d  = sat_q;
    if (wrap) begin
      if (tick_q == TICK_MAX) sat_d = 1'b1;
      else                    tick_d = tick_q + CNT_WIDTH'(1);
    end
    stop = (mode_q == MODE_PERIOD) ? ev_rise : ev_fall;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pre_q        <= '0;
      tick_q       <= '0;
      sat_q        <= 1'b0;
      mode_q       <= MODE_PULSE;
      capture_q    <= '0;
      overflow_q   <= 1'b0;
      busy_q       <= 1'b0;
      capture_it_q <= 1'b0;
    end else if (!enable) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      capture_it_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (arm) begin
            state_q      <= ARMED;
            busy_q       <= 1'b1;
            capture_it_q <= 1'b0;
            overflow_q   <= 1'b0;
            pre_q        <= '0;
            tick_q       <= '0;
            sat_q        <= 1'b0;
          end
        end
        ARMED: begin
          pre_q  <= '0;
          tick_q <= '0;
          sat_q  <= 1'b0;
          // A new arm restarts the wait and discards a coincident rise.
          if (!arm && ev_rise) begin
            state_q <= COUNT;
            mode_q  <= mode;
          end
        end
        COUNT: begin
          if (stop) begin
            state_q      <= DONE;
            busy_q       <= 1'b0;
            capture_q    <= tick_d;
            overflow_q   <= sat_d;
            capture_it_q <= 1'b1;
          end else if (arm) begin
            state_q <= ARMED;
            pre_q   <= '0;
            tick_q  <= '0;
            sat_q   <= 1'b0;
          end else begin
            pre_q  <= pre_d;
            tick_q <= tick_d;
            sat_q  <= sat_d;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign capture    = capture_q;
  assign overflow   = overflow_q;
  assign busy       = busy_q;
  assign capture_it = capture_it_q;

endmodule

// File: tb/tb_interval_capture.sv
// Scoreboard bench for interval_capture: expected {overflow, capture} pairs are
// queued as each event waveform is driven and checked on every capture_it rise.
module tb_interval_capture;

  localparam int A_W  = 8;
  localparam int C_W  = 16;
  localparam int C_W4 = 4;
  localparam int HALF = 20;

  logic           clk = 1'b0;
  logic           rst, enable, arm, mode, event_in;
  logic [A_W-1:0] div_a;

  logic [C_W-1:0]  capture;
  logic            overflow, busy, capture_it;
  logic [C_W4-1:0] capture4;
  logic            overflow4, busy4, capture_it4;

  int checks   = 0;
  int failures = 0;

  logic [C_W:0] exp_q[$];
  logic [C_W:0] mon_e;
  logic         cap_it_prev = 1'b0;

  interval_capture #(.A_WIDTH(A_W), .CNT_WIDTH(C_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .arm        (arm),
    .mode       (mode),
    .div_a      (div_a),
    .event_in   (event_in),
    .capture    (capture),
    .overflow   (overflow),
    .busy       (busy),
    .capture_it (capture_it)
  );

  interval_capture #(.A_WIDTH(A_W), .CNT_WIDTH(C_W4)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .arm        (arm),
    .mode       (mode),
    .div_a      (div_a),
    .event_in   (event_in),
    .capture    (capture4),
    .overflow   (overflow4),
    .busy       (busy4),
    .capture_it (capture_it4)
  );

  // Clock / watchdog
  always #HALF clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (capture_it && !cap_it_prev) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_capture", 32'(capture), 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check_val("capture", 32'(capture), 32'(mon_e[C_W-1:0]));
        check_val("overflow", 32'(overflow), 32'(mon_e[C_W]));
      end
    end
    cap_it_prev <= capture_it;
  end

  // Driver tasks
  task automatic do_arm();
    @(posedge clk); #1 arm = 1'b1;
    @(posedge clk); #1 arm = 1'b0;
  endtask

  task automatic pulse(input int width, input int offs);
    @(posedge clk); #(offs) event_in = 1'b1;
    repeat (width) @(posedge clk);
    #(offs) event_in = 1'b0;
  endtask

  task automatic wait_cap_it(input string tag, input int max_cycles);
    int n = 0;
    while (!capture_it && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    if (!capture_it) check_val({tag, "_timeout"}, 32'(capture_it), 32'd1);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; arm = 1'b0; mode = 1'b0; div_a = '0; event_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_capture", 32'(capture), 32'd0);
    check_val("rst_overflow", 32'(overflow), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_cap_it", 32'(capture_it), 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Pulse width, div 33, 165 cycles -> 5; capture_it 3 cycles after fall
    mode = 1'b0; div_a = 8'd33;
    do_arm();
    check_val("armed_busy", 32'(busy), 32'd1);
    exp_q.push_back({1'b0, 16'd5});
    pulse(165, 13);
    @(posedge clk); @(posedge clk); #1;
    check_val("cap_it_before_lat3", 32'(capture_it), 32'd0);
    @(posedge clk); #1;
    check_val("cap_it_at_lat3", 32'(capture_it), 32'd1);
    check_val("done_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);

    // Period, div 10, 200-cycle square wave -> 20
    mode = 1'b1; div_a = 8'd10;
    do_arm();
    exp_q.push_back({1'b0, 16'd20});
    @(posedge clk); #7 event_in = 1'b1;
    repeat (100) @(posedge clk); #7 event_in = 1'b0;
    repeat (100) @(posedge clk); #7 event_in = 1'b1;
    wait_cap_it("period", 10);
    repeat (97) @(posedge clk); #7 event_in = 1'b0;
    repeat (100) @(posedge clk); #7 event_in = 1'b1;
    repeat (100) @(posedge clk); #7 event_in = 1'b0;
    repeat (5) @(posedge clk); #1;
    check_val("period_cap_it_hold", 32'(capture_it), 32'd1);
    check_val("period_capture_hold", 32'(capture), 32'd20);
    arm = 1'b1;
    @(posedge clk); #1;
    check_val("cap_it_clear_on_arm", 32'(capture_it), 32'd0);
    check_val("rearm_busy", 32'(busy), 32'd1);
    arm = 1'b0;

    // Prescaler zero behaves as one
    mode = 1'b0; div_a = 8'd0;
    do_arm();
    exp_q.push_back({1'b0, 16'd37});
    pulse(37, 29);
    wait_cap_it("div0", 10);

    // Saturation on the 4-bit instance, no wrap
    div_a = 8'd1;
    do_arm();
    exp_q.push_back({1'b0, 16'd40});
    pulse(40, 5);
    wait_cap_it("ovf", 10);
    #1;
    check_val("ovf4_capture", 32'(capture4), 32'd15);
    check_val("ovf4_overflow", 32'(overflow4), 32'd1);
    check_val("ovf4_cap_it", 32'(capture_it4), 32'd1);

    // Re-arm 50 cycles into COUNT, then a full 100-cycle pulse
    do_arm();
    @(posedge clk); #9 event_in = 1'b1;
    repeat (50) @(posedge clk);
    #1 arm = 1'b1;
    @(posedge clk); #1 arm = 1'b0;
    check_val("restart_busy", 32'(busy), 32'd1);
    check_val("restart_cap_it", 32'(capture_it), 32'd0);
    check_val("restart_capture_kept", 32'(capture), 32'd40);
    repeat (10) @(posedge clk); #9 event_in = 1'b0;
    repeat (10) @(posedge clk);
    exp_q.push_back({1'b0, 16'd100});
    pulse(100, 9);
    wait_cap_it("restart", 10);

    // Enable low mid-COUNT
    do_arm();
    @(posedge clk); #9 event_in = 1'b1;
    repeat (20) @(posedge clk);
    #1 enable = 1'b0;
    @(posedge clk); #1;
    check_val("en_low_busy", 32'(busy), 32'd0);
    check_val("en_low_cap_it", 32'(capture_it), 32'd0);
    check_val("en_low_overflow", 32'(overflow), 32'd0);
    check_val("en_low_capture_kept", 32'(capture), 32'd100);
    enable = 1'b1;
    #8 event_in = 1'b0;
    repeat (10) @(posedge clk);

    // Reset mid-COUNT
    do_arm();
    @(posedge clk); #9 event_in = 1'b1;
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check_val("midrst_capture", 32'(capture), 32'd0);
    check_val("midrst_busy", 32'(busy), 32'd0);
    check_val("midrst_cap_it", 32'(capture_it), 32'd0);
    check_val("midrst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    repeat (5) @(posedge clk); #9 event_in = 1'b0;
    repeat (10) @(posedge clk); #1;
    check_val("midrst_no_cap_it", 32'(capture_it), 32'd0);

    // Randomized pulse widths and dividers
    mode = 1'b0;
    for (int i = 0; i < 64; i++) begin
      int w, p, offs;
      div_a = 8'(($urandom_range(0, 12)));
      w     = int'($urandom_range(1, 80));
      offs  = int'($urandom_range(2, 38));
      p     = (div_a == 8'd0) ? 1 : int'(div_a);
      do_arm();
      exp_q.push_back({1'b0, 16'(w / p)});
      pulse(w, offs);
      wait_cap_it("rand", 10);
      repeat (2) @(posedge clk);
    end

    repeat (5) @(posedge clk);
    check_val("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
